// File: rtl/run_halt_dumper.sv
// Run monitor: counts cycles until the CPU reaches a halt PC or a cycle timeout, then
// freezes the core and streams a framed dump (header, cycles, regs, RAM window).
module run_halt_dumper #(
    parameter int             XLEN      = 32,
    parameter logic [XLEN-1:0] HALT_PC  = XLEN'('h2000),
    parameter int             REG_COUNT = 32,
    parameter logic [XLEN-1:0] MEM_BASE = XLEN'('h1000),
    parameter int             MEM_WORDS = 64,
    parameter logic [31:0]    TIMEOUT   = 32'd0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_pc_valid,
    output logic            o_stall,
    output logic [4:0]      o_reg_addr,
    input  logic [XLEN-1:0] i_reg_data,
    output logic [XLEN-1:0] o_mem_addr,
    input  logic [XLEN-1:0] i_mem_data,
    output logic            o_tx_valid,
    output logic [XLEN-1:0] o_tx_data,
    input  logic            i_tx_ready,
    output logic [31:0]     o_cycles,
    output logic            o_done,
    output logic            o_timeout
);
    typedef enum logic [2:0] {S_RUN, S_HDR, S_CYC, S_REGS, S_MEM, S_DONE} state_t;

    state_t      state, state_nxt;
    logic        rd_wait;
    logic [31:0] idx;
    logic        pc_hit, to_hit, halt, xfer, last_reg, last_mem;

    always_comb begin
        pc_hit   = i_pc_valid && (i_pc == HALT_PC);
        to_hit   = (TIMEOUT != 32'd0) && (o_cycles == TIMEOUT - 32'd1);
        halt     = (state == S_RUN) && (pc_hit || to_hit);
        xfer     = o_tx_valid && i_tx_ready;
        last_reg = (idx == 32'(REG_COUNT - 1));
        last_mem = (idx == 32'(MEM_WORDS - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= S_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (halt) state_nxt = S_HDR;
            S_HDR:   if (xfer) state_nxt = S_CYC;
            S_CYC:   if (xfer) state_nxt = S_REGS;
            S_REGS:  if (xfer && last_reg) state_nxt = S_MEM;
            S_MEM:   if (xfer && last_mem) state_nxt = S_DONE;
            default: state_nxt = S_DONE;
        endcase
    end

    always_comb begin
        o_stall = (state != S_RUN);
        o_done  = (state == S_DONE);
    end

    // rd_wait marks the clock in which the word for the current slot is being read;
    // the word is latched into o_tx_data at the end of it and then held until accepted.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_cycles   <= '0;
            o_timeout  <= 1'b0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
            o_reg_addr <= '0;
            o_mem_addr <= '0;
            idx        <= '0;
            rd_wait    <= 1'b0;
        end else begin
            if (state == S_RUN && o_cycles != 32'hFFFF_FFFF)
                o_cycles <= o_cycles + 32'd1;
            if (halt) begin
                o_timeout <= to_hit && !pc_hit;
                rd_wait   <= 1'b1;
            end
            if (rd_wait) begin
                rd_wait    <= 1'b0;
                o_tx_valid <= 1'b1;
                case (state)
                    S_HDR:   o_tx_data <= XLEN'(32'hD0D0_0000) | XLEN'(o_timeout);
                    S_CYC:   o_tx_data <= XLEN'(o_cycles);
                    S_REGS:  o_tx_data <= i_reg_data;
                    S_MEM:   o_tx_data <= i_mem_data;
                    default: o_tx_valid <= 1'b0;
                endcase
            end
            if (xfer) begin
                o_tx_valid <= 1'b0;
                rd_wait    <= !(state == S_MEM && last_mem);
                case (state)
                    S_CYC: begin
                        o_reg_addr <= '0;
                        idx        <= '0;
                    end
                    S_REGS: begin
                        if (last_reg) begin
                            o_mem_addr <= MEM_BASE;
                            idx        <= '0;
                        end else begin
                            o_reg_addr <= o_reg_addr + 5'd1;
                            idx        <= idx + 32'd1;
                        end
                    end
                    S_MEM: begin
                        o_mem_addr <= o_mem_addr + XLEN'(1);
                        idx        <= idx + 32'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_run_halt_dumper.sv
// Directed bench: PC halt, timeout halt, backpressure, mid-dump reset and RAM address wrap.
module tb_run_halt_dumper;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rf_m(input logic [4:0] a);
        return (a == 5'd5) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(a);
    endfunction
    function automatic logic [31:0] mem_m(input logic [31:0] a);
        return (a == 32'h1003) ? 32'h1234_5678 : a ^ 32'h5A5A_0000;
    endfunction

    // DUT a: PC-halt configuration
    logic        a_rst, a_pcv, a_stall, a_vld, a_rdy, a_done, a_to;
    logic [31:0] a_pc, a_rdata, a_maddr, a_mdata, a_data, a_cyc;
    logic [4:0]  a_raddr;
    assign a_rdata = rf_m(a_raddr);
    assign a_mdata = mem_m(a_maddr);

    run_halt_dumper u_a (
        .i_clk(clk), .i_rst(a_rst), .i_pc(a_pc), .i_pc_valid(a_pcv), .o_stall(a_stall),
        .o_reg_addr(a_raddr), .i_reg_data(a_rdata), .o_mem_addr(a_maddr), .i_mem_data(a_mdata),
        .o_tx_valid(a_vld), .o_tx_data(a_data), .i_tx_ready(a_rdy), .o_cycles(a_cyc),
        .o_done(a_done), .o_timeout(a_to)
    );

    // DUT b: timeout and address-wrap configuration
    logic        b_rst, b_pcv, b_stall, b_vld, b_rdy, b_done, b_to;
    logic [31:0] b_pc, b_rdata, b_maddr, b_mdata, b_data, b_cyc;
    logic [4:0]  b_raddr;
    assign b_rdata = rf_m(b_raddr);
    assign b_mdata = mem_m(b_maddr);

    run_halt_dumper #(.REG_COUNT(4), .MEM_BASE(32'hFFFF_FFFE), .MEM_WORDS(4), .TIMEOUT(32'd100)) u_b (
        .i_clk(clk), .i_rst(b_rst), .i_pc(b_pc), .i_pc_valid(b_pcv), .o_stall(b_stall),
        .o_reg_addr(b_raddr), .i_reg_data(b_rdata), .o_mem_addr(b_maddr), .i_mem_data(b_mdata),
        .o_tx_valid(b_vld), .o_tx_data(b_data), .i_tx_ready(b_rdy), .o_cycles(b_cyc),
        .o_done(b_done), .o_timeout(b_to)
    );

    logic        sel;
    logic        cvld;
    logic [31:0] cdata, caddr;
    assign cvld  = sel ? b_vld   : a_vld;
    assign cdata = sel ? b_data  : a_data;
    assign caddr = sel ? b_maddr : a_maddr;

    logic [31:0] got[$];
    logic [31:0] gaddr[$];
    logic [31:0] exp_q[$];

    task automatic build(input logic to, input logic [31:0] cyc, input int nreg,
                         input logic [31:0] base, input int nmem);
        exp_q.delete();
        exp_q.push_back(32'hD0D0_0000 | {31'b0, to});
        exp_q.push_back(cyc);
        for (int i = 0; i < nreg; i++) exp_q.push_back(rf_m(5'(i)));
        for (int j = 0; j < nmem; j++) exp_q.push_back(mem_m(base + 32'(j)));
    endtask

    // Pulls n words from the selected DUT; pct = percent of clocks with ready low.
    task automatic collect(input int n, input int pct);
        logic        pv, pr, r;
        logic [31:0] pd;
        int          guard;
        pv = 1'b0; pr = 1'b0; pd = '0; guard = 0;
        got.delete(); gaddr.delete();
        while (got.size() < n && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (pv && !pr) begin
                chk("hold_valid", cvld, 1'b1);
                chk("hold_data", cdata, pd);
            end
            r = ($urandom_range(99) >= pct);
            if (sel) b_rdy = r; else a_rdy = r;
            if (cvld && r) begin
                got.push_back(cdata);
                gaddr.push_back(caddr);
            end
            pv = cvld; pr = r; pd = cdata;
        end
        if (got.size() < n) chk("collect_budget", got.size(), n);
        @(negedge clk);
        a_rdy = 1'b0; b_rdy = 1'b0;
    endtask

    task automatic cmp_frame(input string tag);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) chk($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
    endtask

    task automatic chk_end(input string tag);
        repeat (2) @(negedge clk);
        chk({tag, "_done"}, a_done, 1'b1);
        chk({tag, "_vld"}, a_vld, 1'b0);
        chk({tag, "_stall"}, a_stall, 1'b1);
    endtask

    initial begin
        sel = 1'b0;
        a_rst = 1'b0; a_pc = '0; a_pcv = 1'b0; a_rdy = 1'b0;
        b_rst = 1'b0; b_pc = '0; b_pcv = 1'b0; b_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stall", a_stall, 1'b0);
        chk("rst_vld", a_vld, 1'b0);
        chk("rst_cyc", a_cyc, 32'd0);
        chk("rst_done", a_done, 1'b0);

        // Run 1: PC walks 0,4,...,0x2000, ready always high
        a_rst = 1'b1; a_pc = 32'h0; a_pcv = 1'b1;
        for (int k = 1; k <= 2048; k++) begin
            @(negedge clk);
            a_pc = 32'(4 * k);
        end
        chk("pre_halt_stall", a_stall, 1'b0);
        @(negedge clk);
        chk("halt_stall", a_stall, 1'b1);
        chk("halt_cycles", a_cyc, 32'd2049);
        chk("halt_timeout", a_to, 1'b0);
        build(1'b0, 32'd2049, 32, 32'h1000, 64);
        collect(98, 0);
        cmp_frame("run1");
        chk("run1_w7", got[7], 32'hDEAD_BEEF);
        chk("run1_w37", got[37], 32'h1234_5678);
        chk("run1_hdr", got[0], 32'hD0D0_0000);
        a_pc = 32'h2000;
        chk_end("run1");
        chk("run1_cyc_frozen", a_cyc, 32'd2049);

        // Run 2: invalid halt PC ignored, then abort mid-REGS with reset
        a_rst = 1'b0; a_pcv = 1'b0;
        @(negedge clk);
        a_rst = 1'b1; a_pc = 32'h2000; a_pcv = 1'b0;
        @(negedge clk); a_pc = 32'h0; a_pcv = 1'b1;
        @(negedge clk); a_pc = 32'h2000;
        @(negedge clk);
        chk("run2_stall", a_stall, 1'b1);
        chk("run2_cycles", a_cyc, 32'd3);
        collect(10, 30);
        a_rst = 1'b0;
        #1;
        chk("abort_stall", a_stall, 1'b0);
        chk("abort_vld", a_vld, 1'b0);
        chk("abort_data", a_data, 32'd0);
        chk("abort_raddr", 32'(a_raddr), 32'd0);
        chk("abort_maddr", a_maddr, 32'd0);
        chk("abort_cyc", a_cyc, 32'd0);
        chk("abort_done", a_done, 1'b0);
        chk("abort_to", a_to, 1'b0);

        // Run 3: short run, full frame under 30% backpressure
        @(negedge clk);
        a_rst = 1'b1; a_pc = 32'h0; a_pcv = 1'b1;
        @(negedge clk); a_pc = 32'h4;
        @(negedge clk); a_pc = 32'h8;
        @(negedge clk); a_pc = 32'h2000;
        @(negedge clk);
        chk("run3_cycles", a_cyc, 32'd4);
        build(1'b0, 32'd4, 32, 32'h1000, 64);
        collect(98, 30);
        cmp_frame("run3");
        chk_end("run3");

        // Run 4: timeout halt with wrapping RAM window
        sel = 1'b1;
        b_rst = 1'b1; b_pc = 32'h0; b_pcv = 1'b1;
        repeat (99) @(negedge clk);
        chk("to_pre_cycles", b_cyc, 32'd99);
        chk("to_pre_stall", b_stall, 1'b0);
        @(negedge clk);
        chk("to_cycles", b_cyc, 32'd100);
        chk("to_stall", b_stall, 1'b1);
        chk("to_flag", b_to, 1'b1);
        build(1'b1, 32'd100, 4, 32'hFFFF_FFFE, 4);
        collect(10, 30);
        cmp_frame("to");
        chk("to_hdr", got[0], 32'hD0D0_0001);
        chk("wrap_a0", gaddr[6], 32'hFFFF_FFFE);
        chk("wrap_a1", gaddr[7], 32'hFFFF_FFFF);
        chk("wrap_a2", gaddr[8], 32'h0000_0000);
        chk("wrap_a3", gaddr[9], 32'h0000_0001);
        repeat (2) @(negedge clk);
        chk("to_done", b_done, 1'b1);
        chk("to_flag_sticky", b_to, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
